instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch front end for the single-issue RISC-V core. It owns the fetch PC and drives the word address into the combinational instruction memory. It captures the returned word into a small prefetch FIFO and presents instructions with their PCs to decode over a valid/ready handshake. Branch and jump redirects from execute flush the FIFO and restart fetch at the new PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC loaded on reset; bits [1:0] must be zero.
- `FIFO_DEPTH`, default 2: prefetch entries; power of two, ≥2.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset. Assertion acts immediately; deassertion is synchronous to `clk`.
- `imem_addr` output 32: byte address to instruction memory; always equals the fetch PC; bits [1:0] always 0.
- `imem_instr` input 32: instruction word; combinational function of `imem_addr`, valid in the same cycle.
- `if_valid` output 1: FIFO head holds an instruction.
- `if_ready` input 1: decode accepts the head this cycle.
- `if_instr` output 32: head instruction; 0 when `if_valid`=0.
- `if_pc` output 32: head PC; 0 when `if_valid`=0.
- `redirect_valid` input 1: flush and restart fetch.
- `redirect_pc` input 32: new fetch PC; bits [1:0] ignored and forced to 0.
- `halted` output 1: fetch stopped on an all-zero word; only meaningful with the halt feature enabled.

## Operation
- Fetch state: `fetch_pc` (32 b), FIFO of {pc, instr} entries, occupancy count (width $clog2(FIFO_DEPTH)+1), and a 2-state FSM: FETCH and HALT.
- Push condition: FSM in FETCH, no redirect, and the FIFO is not full, or is full with a pop in the same cycle.
  - A push writes {fetch_pc, imem_instr}.
  - A push advances `fetch_pc` by 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- Pop: `if_valid && if_ready`. The head advances and the count decrements. With a simultaneous push, the count is unchanged.
- Redirect has the highest priority:
  - On the next edge, the FIFO is emptied (count=0, pointers reset).
  - `fetch_pc` ← {redirect_pc[31:2], 2'b00}, and the FSM goes to FETCH.
  - No push occurs that cycle. A handshake in the same cycle is still a legal accept by decode.
- No push when full without a pop; `fetch_pc` holds.
- FSM (halt feature only):
  - FETCH→HALT when the push condition holds and `imem_instr`==32'h0. The zero word is not pushed and `fetch_pc` holds.
  - HALT→FETCH only on redirect.
  - In HALT, remaining FIFO entries still drain normally.

## Timing
- Reset values:
  - `fetch_pc`=RESET_PC, so `imem_addr`=RESET_PC.
  - `if_valid`=0, `if_instr`=0, `if_pc`=0, `halted`=0.
  - FIFO empty; FSM=FETCH.
- Latency: the word fetched in cycle N appears at the head with `if_valid`=1 in cycle N+1 (if the FIFO was empty). The first instruction after reset deassertion is visible one cycle after the first edge.
- Throughput: one instruction per cycle with `if_ready` held high.
- Redirect: `imem_addr` shows the target in the cycle after `redirect_valid`. The first redirected instruction is valid the cycle after that (2 cycles redirect-to-valid).
- Back-to-back redirects: the last one wins; each one flushes.
- `if_instr`/`if_pc` must stay stable while `if_valid`=1 and `if_ready`=0.
- Reset mid-stream: all state returns to reset values immediately; in-flight entries are discarded.

## Configuration
- `FETCH_HALT_ON_ZERO_EN` defined:
  - The HALT state exists; an all-zero word stops fetch as described.
  - `halted` is 1 exactly while the FSM is in HALT.
- `FETCH_HALT_ON_ZERO_EN` undefined:
  - No HALT state; zero words are pushed like any other instruction.
  - `halted` is tied to 0.

## Test plan
- Reset then stream: memory model returns 0x0000_0013 @0x0, 0x0000_10B7 @0x4, 0x0000_A183 @0x8; `if_ready`=1 → `if_valid` rises 1 cycle after the first edge; outputs {0x0,0x13}, {0x4,0x10B7}, {0x8,0xA183} on consecutive cycles.
- Backpressure: `if_ready`=0 for 5 cycles from reset → count saturates at FIFO_DEPTH, `imem_addr` holds at 0x8 (depth 2), head stays {0x0,0x13}. Release → in-order delivery with no loss or duplicates.
- Redirect: with the FIFO full, pulse `redirect_valid` with `redirect_pc`=0x0000_0007 → next cycle `if_valid`=0 and `imem_addr`=0x4; the cycle after, head={0x4,0x10B7}.
- Redirect during pop: `if_ready`=1 and redirect in the same cycle → the head is consumed once and nothing stale appears afterwards.
- Halt (macro on): memory returns 0 at 0x2C, program 0x0–0x28 nonzero → eleven instructions delivered, then `halted`=1 and `imem_addr` stuck at 0x2C. Redirect to 0x0 → `halted`=0 and the stream restarts. With the macro off → {0x2C,0x0} is delivered and `halted` stays 0.
- Wrap: redirect to 0xFFFF_FFFC → delivers pc 0xFFFF_FFFC, then pc 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Instruction fetch front end. Owns the fetch PC, reads the
//            combinational instruction memory, buffers {pc, instr} pairs in a
//            small prefetch FIFO and hands them to decode over valid/ready.
//            Redirects from execute flush the FIFO and restart fetch.
// Options  : FETCH_HALT_ON_ZERO_EN - when defined, an all-zero instruction
//            word stops fetch (HALT state) until the next redirect.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam int               PTR_W            = $clog2(FIFO_DEPTH);
    localparam int               CNT_W            = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT         = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    // Prefetch storage; contents are only observed through the occupancy
    // count, so the data arrays need no reset.
    logic [31:0]      fifo_pc    [FIFO_DEPTH];
    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      fetch_pc;

    logic fetch_active;   // FSM permits fetching
    logic fifo_full;
    logic pop;            // decode accepts the head this cycle
    logic push_slot;      // a word may be captured this cycle
    logic halt_hit;       // captured word is a zero word that stops fetch
    logic push;           // word is actually written into the FIFO

    // Word-alignment bits of the redirect target are discarded by design.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign if_valid  = (count != '0);
    assign fifo_full = (count == FULL_CNT);
    assign pop       = if_valid && if_ready;
    // A full FIFO can still accept a word when the head leaves in the same cycle.
    assign push_slot = fetch_active && !redirect_valid && (!fifo_full || pop);
    assign push      = push_slot && !halt_hit;

`ifdef FETCH_HALT_ON_ZERO_EN
    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a zero word seen on a capture slot halts fetch; only a
    // redirect resumes it. Redirect in FETCH simply stays in FETCH.
    always_comb begin
        state_next = state;
        halt_hit   = 1'b0;
        case (state)
            ST_FETCH: begin
                if (push_slot && (imem_instr == 32'h0)) begin
                    state_next = ST_HALT;
                    halt_hit   = 1'b1;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    assign fetch_active = (state == ST_FETCH);
    assign halted       = (state == ST_HALT);
`else
    assign fetch_active = 1'b1;
    assign halt_hit     = 1'b0;
    assign halted       = 1'b0;
`endif

    // Fetch PC, FIFO pointers and occupancy; redirect flushes and wins over
    // any push or pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC_ALIGNED;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Capture the fetched word together with the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= fetch_pc;
            fifo_instr[wr_ptr] <= imem_instr;
        end
    end

    assign imem_addr = fetch_pc;
    assign if_instr  = if_valid ? fifo_instr[rd_ptr] : 32'h0;
    assign if_pc     = if_valid ? fifo_pc[rd_ptr]    : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit: directed vector table,
//            hand-written halt/reset sequences and a randomized run compared
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_HALT_ON_ZERO_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;

    bit halt_mode  = 1'b0;
    bit rand_zeros = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    // Program image: three fixed words at the bottom, a nonzero address hash
    // elsewhere, and optional zero words for the halt scenarios.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input bit hm, input bit rz);
        if (hm && a == 32'h0000_002C) return 32'h0;
        if (rz && a[5:2] == 4'hB) return 32'h0;
        case (a)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0004: return 32'h0000_10B7;
            32'h0000_0008: return 32'h0000_A183;
            default:       return a ^ 32'h5A5A_0013;
        endcase
    endfunction

    always_comb imem_instr = mem_word(imem_addr, halt_mode, rand_zeros);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [31:0] einstr, input logic [31:0] eaddr, input logic ehalt);
        chk({tag, " valid"},  {31'h0, if_valid}, {31'h0, ev});
        chk({tag, " pc"},     if_pc,             epc);
        chk({tag, " instr"},  if_instr,          einstr);
        chk({tag, " addr"},   imem_addr,         eaddr);
        chk({tag, " halted"}, {31'h0, halted},   {31'h0, ehalt});
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_halt;

    task automatic model_reset();
        mq.delete();
        m_pc   = RST_PC;
        m_halt = 1'b0;
    endtask

    task automatic model_check(input string tag);
        if (mq.size() > 0) chk_out(tag, 1'b1, mq[0].pc, mq[0].instr, m_pc, m_halt);
        else               chk_out(tag, 1'b0, 32'h0, 32'h0, m_pc, m_halt);
    endtask

    // Apply one clock edge's worth of behaviour from the current inputs.
    task automatic model_edge();
        logic [31:0] w;
        bit pop;
        pop = (mq.size() > 0) && if_ready;
        if (redirect_valid) begin
            mq.delete();
            m_pc   = redirect_pc & ~32'h3;
            m_halt = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (!m_halt && mq.size() < DEPTH) begin
                w = mem_word(m_pc, halt_mode, rand_zeros);
                if (HALT_EN && w == 32'h0) begin
                    m_halt = 1'b1;
                end else begin
                    mq.push_back('{pc: m_pc, instr: w});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    // Reset: outputs must return to reset values immediately on assertion.
    task automatic do_reset();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        rst_n          = 1'b0;
        #1;
        chk_out("reset", 1'b0, 32'h0, 32'h0, RST_PC, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        bit          ready;
        bit          redir;
        logic [31:0] rpc;
        bit          ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs[$];
    ent_t got[$];

    initial begin
        rst_n          = 1'b0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Stream from reset with decode always ready.
        vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,      32'h0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'h13,     32'h4});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 32'h10B7,   32'h8});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8, 32'hA183,   32'hC});
        // Backpressure for five cycles from reset, then release.
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,      32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h13,     32'h4});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h13,     32'h8});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h13,     32'h8});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h13,     32'h8});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'h13,     32'h8});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 32'h10B7,   32'hC});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 32'hA183,   32'h10});
        // Redirect with the FIFO full (unaligned target 0x7).
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h7, 1'b1, 32'h8, 32'hA183,   32'h10});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,      32'h4});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 32'h10B7,   32'h8});
        // Redirect while the head is being popped.
        vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h8, 32'hA183, 32'hC});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,      32'h100});
        // Wrap from the top of the address space.
        vecs.push_back('{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h100, 32'h5A5A_0113, 32'h104});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,      32'hFFFF_FFFC});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_FFEF, 32'h0});
        // Back-to-back redirects: last one wins.
        vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h0, 32'h13,    32'h4});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 32'h0,     32'h40});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,      32'h80});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h80, 32'h5A5A_0093, 32'h84});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            if_ready       = vecs[i].ready;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].einstr, vecs[i].eaddr, 1'b0);
            @(posedge clk);
            #1;
        end
        redirect_valid = 1'b0;

        // Halt on a zero word at 0x2C.
        halt_mode = 1'b1;
        do_reset();
        if_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (if_valid) got.push_back('{pc: if_pc, instr: if_instr});
            @(posedge clk);
            #1;
        end
        if (HALT_EN) begin
            chk("halt delivered count", got.size(), 32'd11);
            for (int k = 0; k < got.size() && k < 11; k++)
                chk($sformatf("halt pc%0d", k), got[k].pc, 32'(k * 4));
            chk("halt flag", {31'h0, halted}, 32'h1);
            chk("halt addr stuck", imem_addr, 32'h2C);
        end else begin
            chk("nohalt delivered count", got.size(), 32'd19);
            chk("nohalt zero pc", got[11].pc, 32'h2C);
            chk("nohalt zero instr", got[11].instr, 32'h0);
            chk("nohalt halted", {31'h0, halted}, 32'h0);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk_out("halt restart", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_out("halt resume", 1'b1, 32'h0, 32'h13, 32'h4, 1'b0);
        halt_mode = 1'b0;

        // Randomized run against the reference model, with a mid-stream reset.
        rand_zeros = 1'b1;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk_out("midstream reset", 1'b0, 32'h0, 32'h0, RST_PC, 1'b0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                model_reset();
            end
            if_ready       = ($urandom % 4) != 0;
            redirect_valid = ($urandom % 16) == 0;
            redirect_pc    = (($urandom % 8) == 0) ? $urandom : $urandom_range(0, 255);
            @(negedge clk);
            model_check($sformatf("rand%0d", i));
            model_edge();
            @(posedge clk);
            #1;
        end
        redirect_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
